// File: rtl/viterbi_pkg.sv
// Shared code definitions for the convolutional encoder and the Viterbi decoder:
// default code, rate modes, puncture tables and the frame FSM states.
package viterbi_pkg;

  localparam int K_DEF  = 5;
  localparam int G0_DEF = 'o23;
  localparam int G1_DEF = 'o35;

  typedef enum logic [1:0] {
    RATE_1_2 = 2'd0,
    RATE_2_3 = 2'd1,
    RATE_3_4 = 2'd2
  } mode_e;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } fsm_e;

  // mask bit 0 covers c0, bit 1 covers c1; 1 = transmitted
  function automatic logic [1:0] punct_mask(mode_e m, logic [1:0] ph);
    logic [1:0] r;
    r = 2'b11;
    case (m)
      RATE_2_3: r = (ph == 2'd0) ? 2'b11 : 2'b01;
      RATE_3_4: r = (ph == 2'd0) ? 2'b11 : (ph == 2'd1) ? 2'b01 : 2'b10;
      default:  r = 2'b11;
    endcase
    return r;
  endfunction

  function automatic logic [1:0] punct_period(mode_e m);
    logic [1:0] r;
    case (m)
      RATE_2_3: r = 2'd2;
      RATE_3_4: r = 2'd3;
      default:  r = 2'd1;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/conv_enc_core.sv
// Combinational rate-1/2 encoder step: window {u, s}, two parities, next state.
module conv_enc_core
  import viterbi_pkg::*;
#(
  parameter int K  = K_DEF,
  parameter int G0 = G0_DEF,
  parameter int G1 = G1_DEF
) (
  input  logic         u,
  input  logic [K-2:0] s,
  output logic         c0,
  output logic         c1,
  output logic [K-2:0] s_next
);
  localparam logic [K-1:0] G0M = K'(G0);
  localparam logic [K-1:0] G1M = K'(G1);

  logic [K-1:0] w;

  assign w      = {u, s};
  assign c0     = ^(w & G0M);
  assign c1     = ^(w & G1M);
  assign s_next = w[K-1:1];
endmodule

// File: rtl/conv_encoder_punct.sv
// Convolutional encoder with 2/3, 3/4 puncturing and optional zero-tail flush,
// valid/ready bit stream in, masked 2-bit symbols out through one register.
module conv_encoder_punct
  import viterbi_pkg::*;
#(
  parameter int K       = K_DEF,
  parameter int G0_OCT  = G0_DEF,
  parameter int G1_OCT  = G1_DEF,
  parameter int TAIL_EN = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] mode,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       in_bit,
  input  logic       in_last,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [1:0] out_sym,
  output logic [1:0] out_mask,
  output logic       out_last
);
  localparam int CW = $clog2(K);

  logic [K-2:0]  s_q, s_nxt;
  logic [1:0]    phase_q;
  fsm_e          fsm_q;
  mode_e         mode_q;
  logic          frame_start_q;
  logic [CW-1:0] flush_cnt_q;

  logic          out_free, acc, flush_go, emit, u, c0, c1;
  mode_e         mode_in, eff_mode;
  logic [1:0]    eff_phase, mask, ph_inc;

  assign mode_in   = (mode == 2'd3) ? RATE_1_2 : mode_e'(mode);
  assign out_free  = !out_valid || out_ready;
  assign in_ready  = (fsm_q == RUN) && out_free;
  assign acc       = in_valid && in_ready;
  assign flush_go  = (fsm_q == FLUSH) && out_free;
  assign emit      = acc || flush_go;
  // the first bit of a frame already uses the freshly sampled mode and phase 0
  assign eff_mode  = (acc && frame_start_q) ? mode_in : mode_q;
  assign eff_phase = (acc && frame_start_q) ? 2'd0 : phase_q;
  assign u         = acc & in_bit;
  assign mask      = punct_mask(eff_mode, eff_phase);
  assign ph_inc    = eff_phase + 2'd1;

  conv_enc_core #(.K(K), .G0(G0_OCT), .G1(G1_OCT)) u_core (
    .u      (u),
    .s      (s_q),
    .c0     (c0),
    .c1     (c1),
    .s_next (s_nxt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q           <= '0;
      phase_q       <= 2'd0;
      fsm_q         <= RUN;
      mode_q        <= RATE_1_2;
      frame_start_q <= 1'b1;
      flush_cnt_q   <= '0;
      out_valid     <= 1'b0;
      out_sym       <= 2'b00;
      out_mask      <= 2'b00;
      out_last      <= 1'b0;
    end else if (emit) begin
      s_q       <= s_nxt;
      phase_q   <= (ph_inc == punct_period(eff_mode)) ? 2'd0 : ph_inc;
      out_valid <= 1'b1;
      out_sym   <= {c1, c0} & mask;
      out_mask  <= mask;
      out_last  <= 1'b0;
      if (acc) begin
        if (frame_start_q) begin
          mode_q        <= mode_in;
          frame_start_q <= 1'b0;
        end
        if (in_last) begin
          if (TAIL_EN != 0) begin
            fsm_q       <= FLUSH;
            flush_cnt_q <= CW'(K - 1);
          end else begin
            out_last      <= 1'b1;
            frame_start_q <= 1'b1;
          end
        end
      end else begin
        flush_cnt_q <= flush_cnt_q - 1'b1;
        if (flush_cnt_q == CW'(1)) begin
          out_last      <= 1'b1;
          fsm_q         <= RUN;
          frame_start_q <= 1'b1;
        end
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_conv_encoder_punct.sv
// Bench for conv_encoder_punct: three configurations (K=5 tail, K=3 tail,
// K=5 no tail) driven by directed frames, checked against a reference model.
module tb_conv_encoder_punct;

  typedef struct packed {
    logic [1:0] sym;
    logic [1:0] mask;
    logic       last;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] mode      [3];
  logic       in_valid  [3];
  logic       in_ready  [3];
  logic       in_bit    [3];
  logic       in_last   [3];
  logic       out_valid [3];
  logic       out_ready [3];
  logic [1:0] out_sym   [3];
  logic [1:0] out_mask  [3];
  logic       out_last  [3];

  always #5 clk = ~clk;

  conv_encoder_punct #(.K(5), .G0_OCT('o23), .G1_OCT('o35), .TAIL_EN(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .mode(mode[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_bit(in_bit[0]), .in_last(in_last[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .out_sym(out_sym[0]), .out_mask(out_mask[0]), .out_last(out_last[0]));

  conv_encoder_punct #(.K(3), .G0_OCT('o7), .G1_OCT('o5), .TAIL_EN(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .mode(mode[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_bit(in_bit[1]), .in_last(in_last[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .out_sym(out_sym[1]), .out_mask(out_mask[1]), .out_last(out_last[1]));

  conv_encoder_punct #(.K(5), .G0_OCT('o23), .G1_OCT('o35), .TAIL_EN(0)) dut2 (
    .clk(clk), .rst_n(rst_n), .mode(mode[2]), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .in_bit(in_bit[2]), .in_last(in_last[2]), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
    .out_sym(out_sym[2]), .out_mask(out_mask[2]), .out_last(out_last[2]));

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state per DUT
  int   kd  [3] = '{5, 3, 5};
  int   g0d [3] = '{'o23, 'o7, 'o23};
  int   g1d [3] = '{'o35, 'o5, 'o35};
  int   td  [3] = '{1, 1, 0};
  int   ms  [3];
  int   mph [3];
  int   mm  [3];
  bit   mst [3];
  exp_t exp_mem [3][256];
  int   wp  [3];
  int   rp  [3];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic par(input int v);
    logic p;
    p = 1'b0;
    for (int i = 0; i < 8; i++) p ^= v[i];
    return p;
  endfunction

  function automatic logic [1:0] ref_mask(input int m, input int ph);
    if (m == 1) return (ph == 0) ? 2'b11 : 2'b01;
    if (m == 2) return (ph == 0) ? 2'b11 : (ph == 1) ? 2'b01 : 2'b10;
    return 2'b11;
  endfunction

  function automatic int ref_period(input int m);
    return (m == 1) ? 2 : (m == 2) ? 3 : 1;
  endfunction

  task automatic model_sym(input int d, input int u, input bit last);
    int w;
    logic [1:0] c, mk;
    exp_t e;
    w = (u << (kd[d] - 1)) | ms[d];
    c[0] = par(w & g0d[d]);
    c[1] = par(w & g1d[d]);
    mk = ref_mask(mm[d], mph[d]);
    e.sym = c & mk;
    e.mask = mk;
    e.last = last;
    exp_mem[d][wp[d] % 256] = e;
    wp[d]++;
    ms[d] = w >> 1;
    mph[d] = (mph[d] + 1) % ref_period(mm[d]);
  endtask

  task automatic model_bit(input int d, input int u, input bit last, input int m);
    if (mst[d]) begin
      mm[d] = (m == 3) ? 0 : m;
      mph[d] = 0;
      mst[d] = 1'b0;
    end
    if (!last) model_sym(d, u, 1'b0);
    else begin
      mst[d] = 1'b1;
      if (td[d] != 0) begin
        model_sym(d, u, 1'b0);
        for (int i = 0; i < kd[d] - 1; i++) model_sym(d, 0, i == kd[d] - 2);
      end else model_sym(d, u, 1'b1);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 3; d++) begin
      ms[d] = 0; mph[d] = 0; mm[d] = 0; mst[d] = 1'b1; rp[d] = wp[d];
    end
  endtask

  // drives one bit until accepted; cyc returns cycles spent waiting
  task automatic send(input int d, input bit b, input bit last, output int cyc);
    bit acc;
    in_valid[d] = 1'b1; in_bit[d] = b; in_last[d] = last;
    cyc = 0;
    do begin
      @(negedge clk);
      acc = in_ready[d];
      cyc++;
      if (acc) model_bit(d, int'(b), last, int'(mode[d]));
      @(posedge clk); #1;
    end while (!acc && cyc < 100);
    in_valid[d] = 1'b0; in_bit[d] = 1'b0; in_last[d] = 1'b0;
    if (!acc) chk($sformatf("d%0d accept timeout", d), 32'(acc), 32'd1);
  endtask

  task automatic send_frame(input int d, input logic [15:0] bits, input int n);
    int cyc;
    for (int i = 0; i < n; i++) send(d, bits[i], i == n - 1, cyc);
  endtask

  task automatic drain(input int d);
    int n;
    n = 0;
    while ((rp[d] != wp[d] || out_valid[d]) && n < 200) begin
      @(posedge clk); #2;
      n++;
    end
    chk($sformatf("d%0d drain", d), 32'(n < 200), 32'd1);
  endtask

  // output monitor: scoreboard pops on handshake, hold-stability while stalled
  initial begin
    bit   hold [3];
    exp_t held [3];
    exp_t e;
    for (int d = 0; d < 3; d++) hold[d] = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        for (int d = 0; d < 3; d++) hold[d] = 1'b0;
      end else begin
        for (int d = 0; d < 3; d++) begin
          if (hold[d]) begin
            chk($sformatf("d%0d hold valid", d), 32'(out_valid[d]), 32'd1);
            chk($sformatf("d%0d hold data", d), {27'd0, out_sym[d], out_mask[d], out_last[d]},
                {27'd0, held[d]});
          end
          if (out_valid[d] && out_ready[d]) begin
            if (rp[d] == wp[d]) chk($sformatf("d%0d unexpected symbol", d), 32'd1, 32'd0);
            else begin
              e = exp_mem[d][rp[d] % 256];
              rp[d]++;
              chk($sformatf("d%0d sym #%0d", d, rp[d]), 32'(out_sym[d]), 32'(e.sym));
              chk($sformatf("d%0d mask #%0d", d, rp[d]), 32'(out_mask[d]), 32'(e.mask));
              chk($sformatf("d%0d last #%0d", d, rp[d]), 32'(out_last[d]), 32'(e.last));
            end
          end
          hold[d] = out_valid[d] && !out_ready[d];
          held[d] = '{out_sym[d], out_mask[d], out_last[d]};
        end
      end
    end
  end

  initial begin
    int cyc, lo;
    rst_n = 1'b0;
    for (int d = 0; d < 3; d++) begin
      mode[d] = 2'd0; in_valid[d] = 1'b0; in_bit[d] = 1'b0; in_last[d] = 1'b0;
      out_ready[d] = 1'b1; wp[d] = 0;
    end
    model_reset();
    #12;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("d%0d reset out_valid", d), 32'(out_valid[d]), 32'd0);
      chk($sformatf("d%0d reset out_sym/mask/last", d),
          {27'd0, out_sym[d], out_mask[d], out_last[d]}, 32'd0);
      chk($sformatf("d%0d reset in_ready", d), 32'(in_ready[d]), 32'd1);
    end
    #10 rst_n = 1'b1;
    @(posedge clk); #1;

    // rate 1/2, bits 1,0,1,1 + tail; in_ready low through the 4 flush cycles
    send_frame(0, 16'b1101, 4);
    lo = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (in_ready[0]) break;
      lo++;
    end
    chk("d0 flush in_ready low cycles", 32'(lo), 32'd4);
    drain(0);

    // rate 3/4, same bits
    mode[0] = 2'd2;
    send_frame(0, 16'b1101, 4);
    drain(0);

    // mode changed mid-frame is ignored until the next frame
    mode[0] = 2'd0;
    send(0, 1'b1, 1'b0, cyc);
    mode[0] = 2'd1;
    send(0, 1'b0, 1'b0, cyc);
    send(0, 1'b1, 1'b0, cyc);
    send(0, 1'b1, 1'b1, cyc);
    drain(0);
    send_frame(0, 16'b101, 3);
    drain(0);

    // back-pressure held during flush
    mode[0] = 2'd0;
    send_frame(0, 16'b011, 3);
    out_ready[0] = 1'b0;
    repeat (3) @(posedge clk);
    #1 out_ready[0] = 1'b1;
    drain(0);

    // K=3: two flush symbols; in_last on the first bit in rate 3/4
    send_frame(1, 16'b101, 3);
    drain(1);
    mode[1] = 2'd2;
    send_frame(1, 16'b1, 1);
    drain(1);
    mode[1] = 2'd3;
    send_frame(1, 16'b0110, 4);
    drain(1);

    // no tail: back-to-back frames, one bit per cycle, state carried over
    send(2, 1'b1, 1'b0, cyc); chk("d2 b2b cyc0", 32'(cyc), 32'd1);
    send(2, 1'b1, 1'b1, cyc); chk("d2 b2b cyc1", 32'(cyc), 32'd1);
    send(2, 1'b0, 1'b0, cyc); chk("d2 b2b cyc2", 32'(cyc), 32'd1);
    send(2, 1'b1, 1'b1, cyc); chk("d2 b2b cyc3", 32'(cyc), 32'd1);
    drain(2);

    // async reset with a stalled symbol in the output register
    out_ready[0] = 1'b0;
    send(0, 1'b1, 1'b0, cyc);
    chk("d0 pre-reset out_valid", 32'(out_valid[0]), 32'd1);
    #3 rst_n = 1'b0;
    #1 chk("d0 async reset out_valid", 32'(out_valid[0]), 32'd0);
    chk("d0 async reset out_sym", 32'(out_sym[0]), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    out_ready[0] = 1'b1;
    @(posedge clk); #1;
    send_frame(0, 16'b1, 1);
    drain(0);
    send_frame(2, 16'b11, 2);
    drain(2);

    for (int d = 0; d < 3; d++) chk($sformatf("d%0d scoreboard empty", d), 32'(wp[d] - rp[d]), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
